// File: rtl/accelerator_pkg.sv
// Shared types and constants for the vector register writeback path.
package accelerator_pkg;

    // Writeback sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } wb_state_t;

    // Byte enables for the single scalar result of a reduction, by element width.
    localparam logic [15:0] WBE_SEW8  = 16'h0001;
    localparam logic [15:0] WBE_SEW16 = 16'h0003;
    localparam logic [15:0] WBE_SEW32 = 16'h000F;

    // Element-width code to reduction byte enable; code 3 behaves as 32b.
    function automatic logic [15:0] sew_to_wbe(input logic [1:0] vsew);
        logic [15:0] wbe;
        case (vsew)
            2'd0:    wbe = WBE_SEW8;
            2'd1:    wbe = WBE_SEW16;
            default: wbe = WBE_SEW32;
        endcase
        return wbe;
    endfunction

endpackage

// File: rtl/wb_byte_enable.sv
// Expands a beat's lane count (or a reduction's element width) into
// register-file byte enables. Lane i owns bytes 4i..4i+3.
module wb_byte_enable
    import accelerator_pkg::*;
(
    input  logic [1:0]  lanes,
    input  logic        reduction,
    input  logic [1:0]  vsew,
    output logic [15:0] byte_en
);

    logic [2:0] n_lanes;

    // Lane count 0 encodes a full beat of four lanes.
    always_comb begin
        n_lanes = (lanes == 2'd0) ? 3'd4 : {1'b0, lanes};
        byte_en = '0;
        if (reduction) begin
            byte_en = sew_to_wbe(vsew);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(n_lanes)) begin
                    byte_en[i*4 +: 4] = 4'hF;
                end
            end
        end
    end

endmodule

// File: rtl/vreg_writeback.sv
// Vector register writeback: collects PE result beats for one instruction and
// turns them into register-file writes through a single output register.
//
// Handshakes: a result beat transfers on a rising edge where in_valid && in_ready;
// a register-file write transfers on a rising edge where rf_we && rf_ready, and
// rf_we/rf_waddr/rf_wdata/rf_wbe are held unchanged until that transfer happens.
module vreg_writeback
    import accelerator_pkg::*;
#(
    parameter int LANES = 4
)
(
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  cfg_valid,
    input  logic [4:0]            cfg_vd,
    input  logic [4:0]            cfg_vl,
    input  logic [1:0]            cfg_vsew,
    input  logic                  cfg_reduction,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_data,
    input  logic [1:0]            in_lanes,
    output logic                  rf_we,
    input  logic                  rf_ready,
    output logic [4:0]            rf_waddr,
    output logic [LANES*32-1:0]   rf_wdata,
    output logic [LANES*4-1:0]    rf_wbe,
    output logic                  done
);

    wb_state_t               state_q, state_d;
    logic [4:0]              vd_q, vd_d;
    logic [4:0]              vl_q, vl_d;
    logic [1:0]              vsew_q, vsew_d;
    logic                    red_q, red_d;
    logic [3:0]              beat_q, beat_d;
    logic                    rf_we_q, rf_we_d;
    logic [4:0]              rf_waddr_q, rf_waddr_d;
    logic [LANES*32-1:0]     rf_wdata_q, rf_wdata_d;
    logic [LANES*4-1:0]      rf_wbe_q, rf_wbe_d;
    logic                    done_q, done_d;

    logic [5:0]              total_beats;
    logic                    last_beat;
    logic                    accept;
    logic [LANES*4-1:0]      beat_wbe;

    wb_byte_enable u_be (
        .lanes     (in_lanes),
        .reduction (red_q),
        .vsew      (vsew_q),
        .byte_en   (beat_wbe)
    );

    // Output register can take a new beat in the same cycle it drains.
    assign in_ready    = (state_q == COLLECT) && (!rf_we_q || rf_ready);
    assign accept      = in_valid && in_ready;
    assign total_beats = ({1'b0, vl_q} + 6'd3) >> 2;
    assign last_beat   = ({2'b00, beat_q} == (total_beats - 6'd1));

    assign busy     = (state_q != IDLE);
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_wbe   = rf_wbe_q;
    assign done     = done_q;

    // Next-state, instruction latch and output-register load.
    always_comb begin
        state_d    = state_q;
        vd_d       = vd_q;
        vl_d       = vl_q;
        vsew_d     = vsew_q;
        red_d      = red_q;
        beat_d     = beat_q;
        rf_we_d    = rf_we_q && !rf_ready;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_wbe_d   = rf_wbe_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    vd_d    = cfg_vd;
                    vl_d    = cfg_vl;
                    vsew_d  = cfg_vsew;
                    red_d   = cfg_reduction;
                    beat_d  = '0;
                    state_d = (cfg_vl == 5'd0) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    beat_d = beat_q + 4'd1;
                    if (!red_q) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = vd_q + {1'b0, beat_q};
                        rf_wdata_d = in_data;
                        rf_wbe_d   = beat_wbe;
                    end else if (last_beat) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = vd_q;
                        rf_wdata_d = {{(LANES*32-32){1'b0}}, in_data[31:0]};
                        rf_wbe_d   = beat_wbe;
                    end
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!rf_we_q || rf_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending write.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            vd_q       <= '0;
            vl_q       <= '0;
            vsew_q     <= '0;
            red_q      <= 1'b0;
            beat_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_wbe_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vd_q       <= vd_d;
            vl_q       <= vl_d;
            vsew_q     <= vsew_d;
            red_q      <= red_d;
            beat_q     <= beat_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_wbe_q   <= rf_wbe_d;
            done_q     <= done_d;
        end
    end

endmodule
